// File: rtl/cache_arbiter.sv
// Purpose: shares one 256-bit physical memory port between the icache (read-only)
//          and the dcache (read/write), one line transaction at a time.
// Ports:   i_pmem_* / d_pmem_* are the private per-cache pmem-style interfaces;
//          pmem_* is the shared memory side (commands, address and wdata registered,
//          rdata forwarded combinationally to both caches).
module cache_arbiter #(
  parameter int ARB_MODE = 1,   // 0: dcache always wins a tie, 1: alternate on ties
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 256
) (
  input  logic              clk,
  input  logic              rst,
  // icache side
  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic              i_pmem_read,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  // dcache side
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  // physical memory side
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

  state_t state;
  logic   last_grant;   // 0 = icache, 1 = dcache
  logic   req_i;
  logic   req_d;
  logic   pick_d;

  assign req_i = i_pmem_read;
  assign req_d = d_pmem_read | d_pmem_write;

  // Winner when leaving IDLE; only meaningful when at least one request is up.
  always_comb begin
    pick_d = 1'b0;
    if (req_d) begin
      if (!req_i)
        pick_d = 1'b1;
      else if (ARB_MODE == 0)
        pick_d = 1'b1;
      else
        pick_d = ~last_grant;
    end
  end

  // Both caches see memory read data all the time; it is only valid with their resp.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  // Responses pass straight through in the pmem_resp cycle. Gating with rst keeps an
  // aborted transaction from producing a resp if reset and pmem_resp coincide.
  assign i_pmem_resp = (state == GRANT_I) & pmem_resp & ~rst;
  assign d_pmem_resp = (state == GRANT_D) & pmem_resp & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i | req_d) begin
            last_grant <= pick_d;
            if (pick_d) begin
              state        <= GRANT_D;
              pmem_address <= d_pmem_address;
              pmem_wdata   <= d_pmem_wdata;
              // A simultaneous read+write request is treated as a write.
              pmem_write   <= d_pmem_write;
              pmem_read    <= ~d_pmem_write;
            end else begin
              state        <= GRANT_I;
              pmem_address <= i_pmem_address;
              pmem_read    <= 1'b1;
              pmem_write   <= 1'b0;
            end
          end
        end
        GRANT_I, GRANT_D: begin
          // No timeout: memory is trusted to respond eventually.
          if (pmem_resp) begin
            state      <= DONE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        DONE: begin
          // Turnaround cycle so a cache that just got its resp can drop its request.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single 256-bit physical memory port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two cache instances and physical memory; each cache sees a private pmem-style interface.
- Serves one line transaction at a time, using a small FSM and registered memory-side command outputs.

Parameters:
ARB_MODE, 1, contested-grant policy: 0 = fixed priority to data cache, 1 = round-robin between icache and dcache
ADDR_W, 32, physical address width
LINE_W, 256, cache line width in bits

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
i_pmem_address  input  ADDR_W  icache line address
i_pmem_read  input  1  icache line read request
i_pmem_rdata  output  LINE_W  icache read data
i_pmem_resp  output  1  icache transaction complete
d_pmem_address  input  ADDR_W  dcache line address
d_pmem_wdata  input  LINE_W  dcache writeback data
d_pmem_read  input  1  dcache line read request
d_pmem_write  input  1  dcache line write request
d_pmem_rdata  output  LINE_W  dcache read data
d_pmem_resp  output  1  dcache transaction complete
pmem_address  output  ADDR_W  memory address (registered)
pmem_wdata  output  LINE_W  memory write data (registered)
pmem_read  output  1  memory read command (registered)
pmem_write  output  1  memory write command (registered)
pmem_rdata  input  LINE_W  memory read data
pmem_resp  input  1  memory transaction complete

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: state=IDLE, last_grant=I, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, i_pmem_resp=0, d_pmem_resp=0.
- Read data forwarding: i_pmem_rdata and d_pmem_rdata are combinational copies of pmem_rdata at all times. They are only valid in the cycle where the matching resp is high.
- Request definitions: req_i = i_pmem_read; req_d = d_pmem_read | d_pmem_write.
- FSM states: IDLE, GRANT_I, GRANT_D, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one requester: grant it.
  - Both requesting, ARB_MODE=0: grant D.
  - Both requesting, ARB_MODE=1: grant the requester that is not last_grant.
  - On grant, latch address (and wdata, op for D) into the pmem_* output registers; set last_grant; go to GRANT_x.
- Command registers: pmem_read/pmem_write are high for every cycle in GRANT_x and low in all other states.
- Address/data registers: pmem_address/pmem_wdata hold their latched values until the next grant.
- Op decode:
  - D with d_pmem_write=1 issues a write, even if d_pmem_read is also high (illegal input; write wins).
  - Otherwise D issues a read.
  - I always issues a read.
- GRANT_x:
  - Wait for pmem_resp.
  - In the pmem_resp cycle, x_pmem_resp=1 combinationally for exactly that cycle, and next state is DONE.
  - The other requester's resp stays 0 throughout.
- DONE: one turnaround cycle with no command; resps=0; requests are ignored; then IDLE.
- Latency:
  - Request present in IDLE at cycle t gives command high at t+1.
  - resp in the same cycle as pmem_resp (cycle r).
  - Next grant sampled at r+2; first command of the next transaction at r+3.
- Requester deasserting mid-grant: the transaction still completes and a resp pulse is still given. Requesters must hold request, address and wdata until resp.
- pmem_resp while in IDLE or DONE: ignored.
- Reset mid-transaction: FSM returns to IDLE next cycle and all commands drop. No resp is issued for the aborted transaction.
- No internal timeouts; the FSM waits indefinitely for pmem_resp.

Test Plan:
- Icache-only read: i_pmem_read=1 with address 0x0000_0040; memory responds 3 cycles after the command with rdata=0xA5..A5. Expect pmem_read=1 with pmem_address=0x40 for 3 cycles, a one-cycle i_pmem_resp with i_pmem_rdata=0xA5..A5, and d_pmem_resp=0 throughout.
- Dcache writeback: d_pmem_write=1 with address 0x100 and wdata pattern 0x1234.... Expect pmem_write=1, pmem_read=0, pmem_wdata equal to the pattern, and d_pmem_resp pulsed once.
- Contested, ARB_MODE=0: both requests asserted in the same cycle and held. Expect D served first, I served second, and exactly one DONE cycle between the two transactions.
- Contested, ARB_MODE=1: both requests held for 4 transactions starting from reset. Expect grant order D, I, D, I.
- Simultaneous d_pmem_read=1 and d_pmem_write=1. Expect pmem_write=1 and pmem_read=0.
- Reset mid-transaction: assert rst in the second GRANT_D cycle. Expect pmem_write=0 on the next cycle, state IDLE, no d_pmem_resp, and a subsequent icache request served normally.
